// File: rtl/alu_op_sequencer.sv
// Byte-stream command sequencer for an external 8-bit ALU: header/A/B frames in, registered result out.
// Optional macro ALU_SEQ_ACC_EN enables 2-byte accumulate frames (header bit 3 loads A from the last result).
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic [7:0] out_data,
    output logic [1:0] out_flags,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] settle_cnt_r;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             acc_hdr_s;
    logic [7:0]       acc_val_s;

`ifdef ALU_SEQ_ACC_EN
    logic [7:0] acc_q;

    // Last captured ALU result, reused as operand A by accumulate frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= 8'h00;
        end else if (state_r == EXEC && settle_cnt_r == CNT_LAST) begin
            acc_q <= alu_result;
        end
    end
`endif

    // Handshake decode; in_ready/out_valid are registered so these are glitch-free.
    always_comb begin
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid & out_ready;
`ifdef ALU_SEQ_ACC_EN
        acc_hdr_s  = in_data[3];
        acc_val_s  = acc_q;
`else
        acc_hdr_s  = 1'b0;
        acc_val_s  = 8'h00;
`endif
    end

    // Frame FSM; status outputs are registered together with the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= HDR;
            settle_cnt_r <= '0;
            alu_a        <= 8'h00;
            alu_b        <= 8'h00;
            alu_sel      <= 3'b000;
            out_data     <= 8'h00;
            out_flags    <= 2'b00;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                HDR: begin
                    if (in_xfer_s) begin
                        alu_sel <= in_data[2:0];
                        busy    <= 1'b1;
                        if (acc_hdr_s) begin
                            alu_a   <= acc_val_s;
                            state_r <= GET_B;
                        end else begin
                            state_r <= GET_A;
                        end
                    end
                end
                GET_A: begin
                    if (in_xfer_s) begin
                        alu_a   <= in_data;
                        state_r <= GET_B;
                    end
                end
                GET_B: begin
                    if (in_xfer_s) begin
                        alu_b        <= in_data;
                        settle_cnt_r <= '0;
                        in_ready     <= 1'b0;
                        state_r      <= EXEC;
                    end
                end
                EXEC: begin
                    if (settle_cnt_r == CNT_LAST) begin
                        out_data  <= alu_result;
                        out_flags <= {alu_carry, alu_zero};
                        out_valid <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_xfer_s) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= HDR;
                    end
                end
                default: begin
                    state_r   <= HDR;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, which sets the number of cycles operands are held before the ALU result is captured; values below 1 SHALL behave as 1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports in_data, input, 8 bits; in_valid, input, 1 bit; in_ready, output, 1 bit: the byte-stream command input.
REQ-005 The block SHALL have ports alu_a, output, 8 bits; alu_b, output, 8 bits; alu_sel, output, 3 bits: registered operands and operation select driven to the 8-bit ALU.
REQ-006 The block SHALL have ports alu_result, input, 8 bits; alu_zero, input, 1 bit; alu_carry, input, 1 bit: the ALU result and flags.
REQ-007 The block SHALL have ports out_data, output, 8 bits; out_flags, output, 2 bits as {carry, zero}; out_valid, output, 1 bit; out_ready, input, 1 bit: the result output.
REQ-008 The block SHALL have port busy, output, 1 bit, which is high whenever the state is not HDR.

Function
REQ-009 A transfer SHALL occur on any rising edge where in_valid and in_ready are both high; out_valid and out_ready SHALL define output transfers the same way.
REQ-010 The state machine SHALL have the states HDR, GET_A, GET_B, EXEC and DONE; in_ready SHALL be high only in HDR, GET_A and GET_B.
REQ-011 A frame SHALL consist of a header byte (bits [2:0] = sel, bit [3] = acc, bits [7:4] ignored), then byte A, then byte B.
REQ-012 A header transfer in HDR SHALL latch sel into alu_sel and move to GET_A.
REQ-013 An A transfer SHALL latch in_data into alu_a and move to GET_B.
REQ-014 A B transfer SHALL latch in_data into alu_b, clear the settle counter and move to EXEC.
REQ-015 EXEC SHALL last exactly SETTLE_CYCLES cycles; on its final edge the block SHALL capture alu_result into out_data and {alu_carry, alu_zero} into out_flags, then enter DONE.
REQ-016 out_valid SHALL be high exactly while in DONE; a B transfer on edge t SHALL give out_valid high in cycle t+1+SETTLE_CYCLES.
REQ-017 out_data and out_flags SHALL stay stable while out_valid is high, and SHALL keep their last values after the output transfer.
REQ-018 An output transfer in DONE SHALL move the state to HDR; out_valid SHALL be low in the following cycle.
REQ-019 alu_a, alu_b and alu_sel SHALL hold their values from latching until overwritten by a later frame.
REQ-020 in_valid SHALL have no effect in EXEC or DONE, and out_ready SHALL have no effect outside DONE.
REQ-021 Gaps in in_valid between the bytes of a frame SHALL be allowed, with the state held indefinitely.
REQ-022 An internal 8-bit register acc_q SHALL be loaded with alu_result on every capture.

Reset
REQ-023 While rst is high, the block SHALL force state HDR, and all of alu_a, alu_b, alu_sel, out_data, out_flags, acc_q and the settle counter to 0.
REQ-024 Immediately after reset, out_valid and busy SHALL be 0 and in_ready SHALL be 1.
REQ-025 Reset asserted mid-frame or in DONE SHALL discard the partial frame or pending result with no output transfer.

Configuration
REQ-026 With macro ALU_SEQ_ACC_EN defined, a header with acc=1 SHALL make the frame two bytes (header, B): the header transfer SHALL load alu_a from acc_q and move directly to GET_B.
REQ-027 Without ALU_SEQ_ACC_EN, header bit [3] SHALL be ignored, every frame SHALL be three bytes, and acc_q may be omitted.

Verification
REQ-028 Scenario: SETTLE_CYCLES=1, bench ALU model gives A+B with carry for sel=000; send bytes 0x00, 0x05, 0x03 back-to-back -> out_data=0x08, out_flags=00, out_valid high 2 cycles after the B transfer.
REQ-029 Scenario: send 0x00, 0xFF, 0x01 -> out_data=0x00, out_flags=11 (carry=1, zero=1).
REQ-030 Scenario: hold out_ready low for 5 cycles in DONE while in_valid is high -> out_valid and data stay stable, in_ready stays 0, no byte is consumed.
REQ-031 Scenario: SETTLE_CYCLES=3 -> out_valid rises exactly 4 cycles after the B transfer.
REQ-032 Scenario: assert rst after the header and A bytes -> busy=0 and alu_a=0; a new frame 0x00, 0x02, 0x02 then yields 0x04.
REQ-033 Scenario (ALU_SEQ_ACC_EN): frame 0x00, 0x10, 0x01 gives 0x11; then 0x08, 0x01 -> alu_a=0x11, out_data=0x12 after a 2-byte frame.
